serial_capture_fifo: RTL
========================

SERIAL_CAPTURE_FIFO -- requirements
Module: serial_capture_fifo

Interface
REQ-001 SHALL have parameter CLK_DIV, default 217, meaning clocks per serial bit (25 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, meaning parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame; legal values 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, meaning receive buffer entries; power of two, 2..256.
REQ-006 CLK  in  1  single system clock; all state on rising edge.
REQ-007 IN_PB_RESET  in  1  asynchronous, active-low reset.
REQ-008 IN_SERIAL_RX  in  1  asynchronous serial line, idle high, LSB first.
REQ-009 IN_POP  in  1  pop head entry when OUT_VALID=1.
REQ-010 IN_CLR_ERR  in  1  clear all sticky error flags.
REQ-011 OUT_DATA  out  DATA_BITS  head-of-FIFO byte, first-word fall-through.
REQ-012 OUT_VALID  out  1  FIFO not empty.
REQ-013 OUT_COUNT  out  clog2(FIFO_DEPTH)+1  entries currently held.
REQ-014 OUT_FRAMING_ERR / OUT_PARITY_ERR / OUT_OVERRUN  out  1 each  sticky error flags.

Function
REQ-015 IN_SERIAL_RX SHALL pass through a two-flop synchronizer; all decisions use the synchronized value.
REQ-016 Receiver FSM states SHALL be IDLE, START, DATA, PAR, STOP, BREAK.
REQ-017 IDLE -> START on synchronized falling edge; bit counter loaded for CLK_DIV/2 (integer division).
REQ-018 START: line sampled at half-bit; low -> DATA with counter reloaded to CLK_DIV; high -> IDLE (glitch rejected, no flag, no push).
REQ-019 DATA: DATA_BITS samples, one every CLK_DIV clocks, shifted LSB first; then PAR if PARITY!=0, else STOP.
REQ-020 PAR: one sample; mismatch vs odd/even parity over data bits marks frame bad-parity.
REQ-021 STOP: STOP_BITS samples; any low stop sample -> frame discarded, OUT_FRAMING_ERR set, go BREAK.
REQ-022 BREAK: remain until synchronized line high for one full CLK_DIV period, then IDLE.
REQ-023 Good stop with bad parity: frame discarded, OUT_PARITY_ERR set, go IDLE.
REQ-024 Good frame: pushed to FIFO on the clock after the last stop sample; OUT_VALID/OUT_COUNT reflect it one clock later; FSM returns to IDLE same cycle as push, ready for back-to-back start bit.
REQ-025 Push while FIFO full and IN_POP=0: byte dropped, OUT_OVERRUN set, contents unchanged.
REQ-026 Push while full with IN_POP=1 same cycle: both succeed, OUT_COUNT unchanged, no overrun.
REQ-027 IN_POP while empty SHALL be ignored; pointers and OUT_COUNT unchanged.
REQ-028 Push and pop on non-empty, non-full FIFO same cycle: OUT_COUNT unchanged, ordering preserved.
REQ-029 Read/write pointers SHALL wrap modulo FIFO_DEPTH; OUT_COUNT saturates never exceeds FIFO_DEPTH.
REQ-030 OUT_DATA undefined-free: holds last head value (zero after reset) while OUT_VALID=0.
REQ-031 Error flags sticky until IN_CLR_ERR; a new error event in the same cycle as IN_CLR_ERR SHALL leave its flag set.

Reset
REQ-032 On IN_PB_RESET low, immediately: FSM IDLE, counters 0, synchronizer flops 1, FIFO pointers 0, OUT_DATA 0, OUT_VALID 0, OUT_COUNT 0, all error flags 0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame with no push and no flag; after release, a line already low SHALL not start a frame until a falling edge is seen.

Verification
REQ-034 CLK_DIV=4, 8N1: send 0x55 then 0xA3 back-to-back -> OUT_COUNT=2, pops return 0x55 then 0xA3, no flags.
REQ-035 PARITY=2: send 0x07 with parity bit 0 -> no push, OUT_PARITY_ERR=1; IN_CLR_ERR pulse -> 0.
REQ-036 Stop bit held low 3 bit-times -> OUT_FRAMING_ERR=1, no push; next valid 0x41 after line high received correctly.
REQ-037 FIFO_DEPTH=4: send 5 frames without pop -> OUT_COUNT=4, OUT_OVERRUN=1, first four bytes intact; repeat with IN_POP on 5th push cycle -> no overrun, count 4.
REQ-038 Low glitch of 1 clock on idle line -> no push, no flag, FSM back in IDLE.
REQ-039 IN_PB_RESET low during DATA of 0x3C -> all outputs 0 immediately; following frame 0x81 received correctly.

Source files
------------

// File: rtl/serial_capture_fifo.sv
// serial_capture_fifo: UART-style receiver with sticky error flags feeding a first-word fall-through FIFO
module serial_capture_fifo #(
    parameter int CLK_DIV    = 217,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        CLK,
    input  logic                        IN_PB_RESET,
    input  logic                        IN_SERIAL_RX,
    input  logic                        IN_POP,
    input  logic                        IN_CLR_ERR,
    output logic [DATA_BITS-1:0]        OUT_DATA,
    output logic                        OUT_VALID,
    output logic [$clog2(FIFO_DEPTH):0] OUT_COUNT,
    output logic                        OUT_FRAMING_ERR,
    output logic                        OUT_PARITY_ERR,
    output logic                        OUT_OVERRUN
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam logic [15:0] DIV = 16'(CLK_DIV);
    localparam logic [15:0] HALF = 16'(CLK_DIV / 2);
    localparam logic [3:0] LAST_D = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_S = 4'(STOP_BITS - 1);
    localparam logic [NW-1:0] FULL = NW'(FIFO_DEPTH);
    localparam logic ODD = (PARITY == 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK} state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q, prev_q;
    logic [1:0]           warm_q;
    logic [15:0]          cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bad_q, par_bad_d;
    logic                 rx, fall, tick;
    logic                 push_evt, fe_evt, pe_evt;
    logic                 push_q;
    logic [DATA_BITS-1:0] wdata_q, last_q;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wp_q, rp_q;
    logic [NW-1:0]        count_q;
    logic                 full, do_pop, do_push, ovr_evt;
    logic                 fe_q, pe_q, ovr_q;

    assign rx   = sync2_q;
    assign fall = prev_q & ~rx;
    assign tick = cnt_q == 16'd1;

    // Synchronize the line; prev_q stays low until real line data has cleared the synchronizer,
    // so a line already low at reset release never looks like a falling edge
    always_ff @(posedge CLK or negedge IN_PB_RESET)
        if (!IN_PB_RESET) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b0;
            warm_q  <= '0;
        end else begin
            sync1_q <= IN_SERIAL_RX;
            sync2_q <= sync1_q;
            warm_q  <= {warm_q[0], 1'b1};
            prev_q  <= warm_q[1] & sync2_q;
        end

    // Receiver state register with its bit timer, bit index and shift register
    always_ff @(posedge CLK or negedge IN_PB_RESET)
        if (!IN_PB_RESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
        end

    // Next state: every sample is taken on the cycle the bit timer reaches one
    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == '0) ? cnt_q : cnt_q - 16'd1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        case (state_q)
            S_IDLE: if (fall) begin
                state_d   = S_START;
                cnt_d     = HALF;
                par_bad_d = 1'b0;
            end
            S_START: if (tick) begin
                state_d = rx ? S_IDLE : S_DATA;
                cnt_d   = DIV;
                bit_d   = '0;
            end
            S_DATA: if (tick) begin
                shift_d = {rx, shift_q[DATA_BITS-1:1]};
                cnt_d   = DIV;
                bit_d   = (bit_q == LAST_D) ? 4'd0 : bit_q + 4'd1;
                state_d = (bit_q != LAST_D) ? S_DATA : (PARITY != 0) ? S_PAR : S_STOP;
            end
            S_PAR: if (tick) begin
                par_bad_d = (^shift_q ^ rx) != ODD;
                cnt_d     = DIV;
                state_d   = S_STOP;
            end
            S_STOP: if (tick) begin
                cnt_d   = DIV;
                bit_d   = (!rx || bit_q == LAST_S) ? 4'd0 : bit_q + 4'd1;
                state_d = !rx ? S_BREAK : (bit_q == LAST_S) ? S_IDLE : S_STOP;
            end
            S_BREAK: begin
                cnt_d   = !rx ? DIV : cnt_d;
                state_d = (rx && tick) ? S_IDLE : S_BREAK;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Frame outcome strobes, decided on the final stop-bit sample
    always_comb begin
        fe_evt   = (state_q == S_STOP) && tick && !rx;
        push_evt = (state_q == S_STOP) && tick && rx && bit_q == LAST_S && !par_bad_q;
        pe_evt   = (state_q == S_STOP) && tick && rx && bit_q == LAST_S && par_bad_q;
    end

    assign full      = count_q == FULL;
    assign do_pop    = IN_POP & (count_q != '0);
    assign do_push   = push_q & (~full | do_pop);
    assign ovr_evt   = push_q & full & ~do_pop;
    assign OUT_VALID = count_q != '0;
    assign OUT_COUNT = count_q;
    assign OUT_DATA  = OUT_VALID ? mem_q[rp_q] : last_q;
    assign OUT_FRAMING_ERR = fe_q;
    assign OUT_PARITY_ERR  = pe_q;
    assign OUT_OVERRUN     = ovr_q;

    // FIFO bookkeeping and sticky flags; a new event outranks a simultaneous clear
    always_ff @(posedge CLK or negedge IN_PB_RESET)
        if (!IN_PB_RESET) begin
            push_q  <= 1'b0;
            wdata_q <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            last_q  <= '0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            push_q  <= push_evt;
            wdata_q <= push_evt ? shift_q : wdata_q;
            wp_q    <= wp_q + AW'(do_push);
            rp_q    <= rp_q + AW'(do_pop);
            count_q <= count_q + NW'(do_push) - NW'(do_pop);
            last_q  <= do_pop ? mem_q[rp_q] : last_q;
            fe_q    <= fe_evt | (fe_q & ~IN_CLR_ERR);
            pe_q    <= pe_evt | (pe_q & ~IN_CLR_ERR);
            ovr_q   <= ovr_evt | (ovr_q & ~IN_CLR_ERR);
        end

    // Storage array needs no reset; OUT_DATA never exposes it while empty
    always_ff @(posedge CLK)
        if (do_push) mem_q[wp_q] <= wdata_q;
endmodule
